// File: rtl/midi_pkg.sv
// Shared definitions for the MIDI message parser: FSM state encodings,
// channel-voice status nibbles and byte-class boundaries.
package midi_pkg;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_D1   = 2'd1;
   localparam logic [1:0] S_D2   = 2'd2;

   localparam logic [3:0] NOTE_OFF = 4'h8;
   localparam logic [3:0] NOTE_ON  = 4'h9;
   localparam logic [3:0] POLY_AT  = 4'hA;
   localparam logic [3:0] CC       = 4'hB;
   localparam logic [3:0] PROG     = 4'hC;
   localparam logic [3:0] CHAN_AT  = 4'hD;
   localparam logic [3:0] BEND     = 4'hE;

   localparam logic [7:0] REALTIME_MIN = 8'hF8;
   localparam logic [7:0] SYSCOM_MIN   = 8'hF0;

   // Number of data bytes that follow a channel status with this high nibble.
   function automatic logic [1:0] msg_data_len(input logic [3:0] nib);
      return ((nib == PROG) || (nib == CHAN_AT)) ? 2'd1 : 2'd2;
   endfunction

endpackage

// File: rtl/midi_byte_classify.sv
// Combinational classification of one received MIDI byte.
// data_len is only meaningful when is_chan_status is set.
module midi_byte_classify
   import midi_pkg::*;
(
   input  logic [7:0] data_byte,
   output logic       is_data,
   output logic       is_chan_status,
   output logic       is_syscom,
   output logic       is_realtime,
   output logic [1:0] data_len
);

   // Byte class decode from the top bit and the F0/F8 boundaries
   always_comb begin
      is_data        = ~data_byte[7];
      is_realtime    = (data_byte >= REALTIME_MIN);
      is_syscom      = (data_byte >= SYSCOM_MIN) && (data_byte < REALTIME_MIN);
      is_chan_status = data_byte[7] && (data_byte < SYSCOM_MIN);
      data_len       = msg_data_len(data_byte[7:4]);
   end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI channel-voice message parser with running status.
// Turns the UART byte stream into single-cycle note-on / note-off events.
// Optional feature: define MIDI_PITCH_BEND_EN to add o_bend / o_bend_vld.
//
// state  | meaning
// S_IDLE | no running status; data bytes are orphans (or SysEx payload)
// S_D1   | running status held, waiting for first data byte
// S_D2   | first data byte held, waiting for second data byte
module midi_msg_parser
   import midi_pkg::*;
#(
   parameter logic [3:0] CHANNEL = 4'd0,
   parameter bit         OMNI    = 1'b0
)(
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  i_byte,
   input  logic        i_byte_vld,
   output logic        o_note_on,
   output logic        o_note_off,
   output logic [6:0]  o_key,
   output logic [6:0]  o_vel,
   output logic [3:0]  o_chan,
   output logic        o_err
`ifdef MIDI_PITCH_BEND_EN
   ,
   output logic [13:0] o_bend,
   output logic        o_bend_vld
`endif
);

   logic       is_data;
   logic       is_chan_status;
   logic       is_syscom;
   logic       is_realtime;
   logic [1:0] data_len;

   logic [1:0] state;
   logic [7:0] status;
   logic       need2;
   logic [6:0] byte1;
   logic       sysex_skip;

   logic       byte_live;
   logic       msg_done;
   logic       chan_ok;
   logic [3:0] nib;
   logic       ev_on;
   logic       ev_off;
   logic       ev_err;

   midi_byte_classify u_classify (
      .data_byte      (i_byte),
      .is_data        (is_data),
      .is_chan_status (is_chan_status),
      .is_syscom      (is_syscom),
      .is_realtime    (is_realtime),
      .data_len       (data_len)
   );

   // Event decode for the byte presented this cycle
   always_comb begin
      byte_live = i_byte_vld && !is_realtime;
      nib       = status[7:4];
      chan_ok   = OMNI || (status[3:0] == CHANNEL);
      msg_done  = byte_live && is_data &&
                  (((state == S_D1) && !need2) || (state == S_D2));
      // Notes are always 2-byte messages, so completion implies S_D2 and byte1 is the key
      ev_on     = msg_done && chan_ok && (nib == NOTE_ON) && (i_byte[6:0] != 7'd0);
      ev_off    = msg_done && chan_ok &&
                  ((nib == NOTE_OFF) || ((nib == NOTE_ON) && (i_byte[6:0] == 7'd0)));
      ev_err    = byte_live &&
                  ((is_chan_status && (state == S_D2)) ||
                   (is_data && (state == S_IDLE) && !sysex_skip));
   end

   // Message assembly state machine with running status
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         status     <= 8'h00;
         need2      <= 1'b0;
         byte1      <= 7'd0;
         sysex_skip <= 1'b0;
      end else if (byte_live) begin
         if (is_chan_status) begin
            status     <= i_byte;
            need2      <= (data_len == 2'd2);
            state      <= S_D1;
            sysex_skip <= 1'b0;
         end else if (is_syscom) begin
            status     <= 8'h00;
            need2      <= 1'b0;
            state      <= S_IDLE;
            sysex_skip <= 1'b1;
         end else begin
            case (state)
               S_IDLE: state <= S_IDLE;
               S_D1: begin
                  if (need2) begin
                     byte1 <= i_byte[6:0];
                     state <= S_D2;
                  end
               end
               S_D2:    state <= S_D1;
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   // Registered event outputs; pulses default low every cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         o_note_on  <= 1'b0;
         o_note_off <= 1'b0;
         o_err      <= 1'b0;
         o_key      <= 7'd0;
         o_vel      <= 7'd0;
         o_chan     <= 4'd0;
      end else begin
         o_note_on  <= ev_on;
         o_note_off <= ev_off;
         o_err      <= ev_err;
         if (ev_on || ev_off) begin
            o_key  <= byte1;
            o_vel  <= (nib == NOTE_ON) ? ev_vel(i_byte[6:0], ev_on) : i_byte[6:0];
            o_chan <= status[3:0];
         end
      end
   end

   // Note-on with zero velocity is reported as a note-off with velocity 0
   function automatic logic [6:0] ev_vel(input logic [6:0] v, input logic on);
      return on ? v : 7'd0;
   endfunction

`ifdef MIDI_PITCH_BEND_EN
   logic ev_bend;

   // Pitch-bend completion on an accepted channel
   always_comb begin
      ev_bend = msg_done && chan_ok && (nib == BEND);
   end

   // Pitch-bend value register, centred at reset
   always_ff @(posedge clk) begin
      if (rst) begin
         o_bend     <= 14'h2000;
         o_bend_vld <= 1'b0;
      end else begin
         o_bend_vld <= ev_bend;
         if (ev_bend) begin
            o_bend <= {i_byte[6:0], byte1};
         end
      end
   end
`endif

endmodule
